// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB3-to-AXI4 single-beat bridge.
package apb2axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] PROT_NONE  = 3'b000;

  // AxSIZE encoding for a full-width beat.
  function automatic logic [2:0] axsize_for(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/apb2axi_if.sv
// APB3 requester bus and AXI4 manager bus bundles used by the bridge.
interface apb2axi_apb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

interface apb2axi_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 16
);
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [7:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/apb2axi_bridge.sv
// APB3 completer that turns each access into one single-beat AXI4 transaction,
// holding PREADY low until the AXI response returns.
module apb2axi_bridge
  import apb2axi_pkg::*;
#(
  parameter int                       AXI4_ADDRESS_WIDTH = 32,
  parameter int                       AXI4_DATA_WIDTH    = 32,
  parameter int                       AXI4_ID_WIDTH      = 16,
  parameter logic [AXI4_ID_WIDTH-1:0] AXI_ID             = '0,
  parameter int                       APB_ADDR_WIDTH     = 32
) (
  input  logic           ACLK,
  input  logic           ARESET,
  apb2axi_apb_if.slave   apb,
  apb2axi_axi_if.master  axi
);

  state_e                          state_q, state_d;
  logic [AXI4_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI4_DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [AXI4_DATA_WIDTH-1:0]      prdata_q, prdata_d;
  logic                            err_q, err_d;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;

  logic awvalid, wvalid, arvalid, bready, rready, pready;
  logic aw_hs, w_hs;

  // VALIDs are decoded from registered state only, so they cannot glitch or
  // drop before their handshake.
  assign awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
  assign wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
  assign arvalid = (state_q == ST_RD_REQ);
  assign bready  = (state_q == ST_WR_RESP);
  assign rready  = (state_q == ST_RD_RESP);
  assign pready  = (state_q == ST_DONE);

  assign aw_hs = awvalid && axi.AWREADY;
  assign w_hs  = wvalid && axi.WREADY;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (apb.PSEL && apb.PENABLE && !pready) begin
          addr_d    = AXI4_ADDRESS_WIDTH'(apb.PADDR);
          wdata_d   = apb.PWDATA;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = apb.PWRITE ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (axi.BVALID) begin
          err_d   = axi.BRESP[1];
          state_d = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        if (axi.ARREADY) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (axi.RVALID) begin
          prdata_d = axi.RDATA;
          err_d    = axi.RRESP[1];
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pready && err_q;
  assign apb.PRDATA  = prdata_q;

  assign axi.AWID    = AXI_ID;
  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = 8'd0;
  assign axi.AWSIZE  = axsize_for(AXI4_DATA_WIDTH);
  assign axi.AWBURST = BURST_INCR;
  assign axi.AWPROT  = PROT_NONE;
  assign axi.AWVALID = awvalid;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = '1;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = wvalid;
  assign axi.BREADY  = bready;
  assign axi.ARID    = AXI_ID;
  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = 8'd0;
  assign axi.ARSIZE  = axsize_for(AXI4_DATA_WIDTH);
  assign axi.ARBURST = BURST_INCR;
  assign axi.ARPROT  = PROT_NONE;
  assign axi.ARVALID = arvalid;
  assign axi.RREADY  = rready;

  // IDs, RLAST and the low response bit carry nothing for single-beat traffic.
  logic unused_resp;
  assign unused_resp = ^{axi.BID, axi.RID, axi.RLAST, axi.BRESP[0], axi.RRESP[0]};

endmodule

// File: tb/tb_apb2axi_bridge.sv
// Directed bench for apb2axi_bridge: APB requester tasks plus a configurable AXI responder.
module tb_apb2axi_bridge;
  import apb2axi_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 16;
  localparam int PAW = 32;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  apb2axi_apb_if #(.ADDR_W(PAW), .DATA_W(DW)) apb ();
  apb2axi_axi_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) axi ();

  apb2axi_bridge #(
    .AXI4_ADDRESS_WIDTH(AW),
    .AXI4_DATA_WIDTH   (DW),
    .AXI4_ID_WIDTH     (IW),
    .AXI_ID            (16'h0000),
    .APB_ADDR_WIDTH    (PAW)
  ) dut (
    .ACLK  (clk),
    .ARESET(arst),
    .apb   (apb),
    .axi   (axi)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Responder configuration (written only by the main sequence)
  int         aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0] bresp_cfg = RESP_OKAY;
  logic [1:0] rresp_cfg = RESP_OKAY;
  logic [DW-1:0] rdata_cfg = '0;

  // AXI responder: READY/VALID rise after a configurable wait, inputs driven just after posedge
  initial begin
    int aw_c, w_c, ar_c, b_c, r_c;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.ARREADY = 1'b0;
    axi.BVALID = 1'b0; axi.BRESP = '0; axi.BID = '0;
    axi.RVALID = 1'b0; axi.RRESP = '0; axi.RDATA = '0; axi.RLAST = 1'b1; axi.RID = '0;
    forever begin
      @(posedge clk); #1;
      if (axi.AWVALID) begin axi.AWREADY = (aw_c >= aw_delay); aw_c++; end
      else begin axi.AWREADY = 1'b0; aw_c = 0; end
      if (axi.WVALID) begin axi.WREADY = (w_c >= w_delay); w_c++; end
      else begin axi.WREADY = 1'b0; w_c = 0; end
      if (axi.ARVALID) begin axi.ARREADY = (ar_c >= ar_delay); ar_c++; end
      else begin axi.ARREADY = 1'b0; ar_c = 0; end
      if (axi.BREADY) begin axi.BVALID = (b_c >= b_delay); axi.BRESP = bresp_cfg; b_c++; end
      else begin axi.BVALID = 1'b0; b_c = 0; end
      if (axi.RREADY) begin
        axi.RVALID = (r_c >= r_delay); axi.RDATA = rdata_cfg; axi.RRESP = rresp_cfg; r_c++;
      end else begin axi.RVALID = 1'b0; r_c = 0; end
    end
  end

  // Bus monitor sampled on the falling edge
  int cyc = 0, aw_hi = 0, w_hi = 0, rready_hi = 0;
  int aw_unstable = 0, overlap = 0, pready_long = 0;
  int aw_hs_cyc = 0, ar_hs_cyc = 0;
  logic          prev_awv = 1'b0, prev_pready = 1'b0;
  logic [AW-1:0] prev_awaddr = '0;
  logic [AW-1:0] hs_awaddr = '0, hs_araddr = '0;
  logic [DW-1:0] hs_wdata = '0;
  logic [IW-1:0] hs_awid = '1, hs_arid = '1;
  logic [7:0]    hs_awlen = '1, hs_arlen = '1;
  logic [2:0]    hs_awsize = '0, hs_arsize = '0, hs_awprot = '1, hs_arprot = '1;
  logic [1:0]    hs_awburst = '0, hs_arburst = '0;
  logic [3:0]    hs_wstrb = '0;
  logic          hs_wlast = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (axi.AWVALID) aw_hi++;
      if (axi.WVALID) w_hi++;
      if (axi.RREADY) rready_hi++;
      if (axi.AWVALID && prev_awv && (axi.AWADDR !== prev_awaddr)) aw_unstable++;
      if ((axi.AWVALID || axi.WVALID || axi.BREADY) && (axi.ARVALID || axi.RREADY)) overlap++;
      if (apb.PREADY && prev_pready) pready_long++;
      if (axi.AWVALID && axi.AWREADY) begin
        hs_awaddr = axi.AWADDR; hs_awid = axi.AWID; hs_awlen = axi.AWLEN;
        hs_awsize = axi.AWSIZE; hs_awburst = axi.AWBURST; hs_awprot = axi.AWPROT;
        aw_hs_cyc = cyc;
      end
      if (axi.WVALID && axi.WREADY) begin
        hs_wdata = axi.WDATA; hs_wstrb = axi.WSTRB; hs_wlast = axi.WLAST;
      end
      if (axi.ARVALID && axi.ARREADY) begin
        hs_araddr = axi.ARADDR; hs_arid = axi.ARID; hs_arlen = axi.ARLEN;
        hs_arsize = axi.ARSIZE; hs_arburst = axi.ARBURST; hs_arprot = axi.ARPROT;
        ar_hs_cyc = cyc;
      end
      prev_awv    = axi.AWVALID;
      prev_awaddr = axi.AWADDR;
      prev_pready = apb.PREADY;
    end
  end

  // Full APB transfer; called just after a rising edge, returns just after one.
  // lat counts cycles from the access phase (0) to the PREADY cycle.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic slverr);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wdata;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      if (apb.PREADY) break;
      lat++;
      if (lat > 200) begin
        check_val("pready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    rdata  = apb.PRDATA;
    slverr = apb.PSLVERR;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    $display("txn %s addr=0x%08h wdata=0x%08h prdata=0x%08h pslverr=%0b lat=%0d",
             wr ? "WR" : "RD", addr, wdata, rdata, slverr, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "simulation timeout");
  end

  initial begin
    int lat, base_a, base_b, wait_n;
    logic [31:0] rd;
    logic err;

    arst = 1'b1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_pready", apb.PREADY, 0);
    check_val("rst_pslverr", apb.PSLVERR, 0);
    check_val("rst_prdata", apb.PRDATA, 0);
    check_val("rst_axi_ctl", {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY}, 0);
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;

    // Basic read, minimum latency
    rdata_cfg = 32'hDEADBEEF; rresp_cfg = RESP_OKAY;
    apb_xfer(1'b0, 32'h0000_1000, 32'h0, lat, rd, err);
    check_val("rd1_lat", lat, 3);
    check_val("rd1_prdata", rd, 32'hDEADBEEF);
    check_val("rd1_pslverr", err, 0);
    check_val("rd1_araddr", hs_araddr, 32'h0000_1000);
    check_val("rd1_arlen", hs_arlen, 0);
    check_val("rd1_arsize", hs_arsize, 2);
    check_val("rd1_arburst", hs_arburst, BURST_INCR);
    check_val("rd1_arprot", hs_arprot, 0);

    // Write with AWREADY stalled 3 cycles
    aw_delay = 3;
    base_a = aw_hi; base_b = w_hi;
    apb_xfer(1'b1, 32'h0000_2004, 32'hCAFE0001, lat, rd, err);
    aw_delay = 0;
    check_val("wr1_lat", lat, 6);
    check_val("wr1_awvalid_cycles", aw_hi - base_a, 4);
    check_val("wr1_wvalid_cycles", w_hi - base_b, 1);
    check_val("wr1_aw_stable", aw_unstable, 0);
    check_val("wr1_awaddr", hs_awaddr, 32'h0000_2004);
    check_val("wr1_wdata", hs_wdata, 32'hCAFE0001);
    check_val("wr1_wstrb", hs_wstrb, 4'hF);
    check_val("wr1_wlast", hs_wlast, 1);
    check_val("wr1_awlen", hs_awlen, 0);
    check_val("wr1_awsize", hs_awsize, 2);
    check_val("wr1_awburst", hs_awburst, BURST_INCR);
    check_val("wr1_awprot", hs_awprot, 0);
    check_val("wr1_pslverr", err, 0);
    check_val("wr1_prdata_kept", rd, 32'hDEADBEEF);

    // Error response mapping
    bresp_cfg = RESP_SLVERR;
    apb_xfer(1'b1, 32'h0000_2008, 32'h1234_5678, lat, rd, err);
    bresp_cfg = RESP_OKAY;
    check_val("wr_slverr_pslverr", err, 1);
    check_val("wr_slverr_lat", lat, 3);
    rresp_cfg = RESP_DECERR; rdata_cfg = 32'h1111_2222;
    apb_xfer(1'b0, 32'h0000_100C, 32'h0, lat, rd, err);
    check_val("rd_decerr_pslverr", err, 1);
    check_val("rd_decerr_prdata", rd, 32'h1111_2222);
    rresp_cfg = RESP_EXOKAY; rdata_cfg = 32'h3333_4444;
    apb_xfer(1'b0, 32'h0000_1008, 32'h0, lat, rd, err);
    check_val("rd_exokay_pslverr", err, 0);
    check_val("rd_exokay_prdata", rd, 32'h3333_4444);
    rresp_cfg = RESP_OKAY;

    // RVALID held off 10 cycles
    r_delay = 10; rdata_cfg = 32'h5555_6666;
    base_a = rready_hi;
    apb_xfer(1'b0, 32'h0000_1010, 32'h0, lat, rd, err);
    r_delay = 0;
    check_val("rslow_lat", lat, 13);
    check_val("rslow_rready_cycles", rready_hi - base_a, 11);
    check_val("rslow_prdata", rd, 32'h5555_6666);

    // Reset while waiting for the write response
    b_delay = 5;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 32'h0000_2010; apb.PWDATA = 32'hAAAA_5555;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    wait_n = 0;
    forever begin
      @(negedge clk);
      if (axi.BREADY) break;
      wait_n++;
      if (wait_n > 50) begin
        check_val("rst_wr_bready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    arst = 1'b1; apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_axi_ctl", {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY}, 0);
    check_val("midrst_pready", apb.PREADY, 0);
    check_val("midrst_pslverr", apb.PSLVERR, 0);
    check_val("midrst_prdata", apb.PRDATA, 0);
    @(posedge clk); #1;
    arst = 1'b0; b_delay = 0;
    $display("txn RST during write response");
    rdata_cfg = 32'h7777_8888;
    apb_xfer(1'b0, 32'h0000_3000, 32'h0, lat, rd, err);
    check_val("postrst_lat", lat, 3);
    check_val("postrst_araddr", hs_araddr, 32'h0000_3000);
    check_val("postrst_prdata", rd, 32'h7777_8888);
    check_val("postrst_pslverr", err, 0);

    // Back-to-back write then read with minimal setup gap
    rdata_cfg = 32'h9999_0000;
    apb_xfer(1'b1, 32'h0000_4000, 32'h0BAD_F00D, lat, rd, err);
    check_val("b2b_wr_lat", lat, 3);
    check_val("b2b_awaddr", hs_awaddr, 32'h0000_4000);
    check_val("b2b_wdata", hs_wdata, 32'h0BAD_F00D);
    apb_xfer(1'b0, 32'h0000_4000, 32'h0, lat, rd, err);
    check_val("b2b_rd_lat", lat, 3);
    check_val("b2b_prdata", rd, 32'h9999_0000);
    check_val("b2b_order", (ar_hs_cyc > aw_hs_cyc), 1);
    check_val("b2b_awid", hs_awid, 0);
    check_val("b2b_arid", hs_arid, 0);

    // Whole-run protocol observations
    check_val("no_channel_overlap", overlap, 0);
    check_val("pready_single_cycle", pready_long, 0);
    check_val("awaddr_stable_all", aw_unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
